// File: rtl/bram_loader_pkg.sv
// Shared FSM encoding and default geometry for the BRAM stream loader.
// No logic; no latency; no backpressure.
// Flow control is handled entirely by the modules that import this package.
package bram_loader_pkg;

    localparam int CNT_BIT_DEF  = 31;
    localparam int DWIDTH_DEF   = 32;
    localparam int AWIDTH_DEF   = 12;
    localparam int MEM_SIZE_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_B0 = 3'd1,
        ST_LOAD_B1 = 3'd2,
        ST_LOAD_B2 = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/bram_wr_port.sv
// Registered BRAM port-A write driver for one bank.
// Latency: 1 cycle from write request to ce/we/addr/d on the BRAM pins.
// No backpressure: the BRAM accepts every write; ce/we low on idle cycles.
module bram_wr_port #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_data,
    output logic [AWIDTH-1:0] o_addr,
    output logic              o_ce,
    output logic              o_we,
    output logic [DWIDTH-1:0] o_d
);

    logic              wr_q,   wr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] dat_q,  dat_d;

    // Address and data hold between writes so the BRAM pins stay quiet.
    always_comb begin
        wr_d   = i_wr;
        addr_d = addr_q;
        dat_d  = dat_q;
        if (i_wr) begin
            addr_d = i_addr;
            dat_d  = i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            dat_q  <= '0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            dat_q  <= dat_d;
        end
    end

    assign o_addr = addr_q;
    assign o_ce   = wr_q;
    assign o_we   = wr_q;
    assign o_d    = dat_q;

endmodule

// File: rtl/bram_stream_loader.sv
// Loads a valid/ready word stream into three BRAM banks (node, weight, bias), count words each.
// Latency: write 1 cycle after each accepted beat; o_done 2 cycles after the last beat.
// Backpressure: s_ready high only while loading a bank. Option: LOADER_CHECKSUM_EN adds o_checksum.
module bram_stream_loader
    import bram_loader_pkg::*;
#(
    parameter int CNT_BIT  = CNT_BIT_DEF,
    parameter int DWIDTH   = DWIDTH_DEF,
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic               o_idle,
    output logic               o_load,
    output logic               o_done,
`ifdef LOADER_CHECKSUM_EN
    output logic [DWIDTH-1:0]  o_checksum,
`endif
    input  logic               s_valid,
    input  logic [DWIDTH-1:0]  s_data,
    output logic               s_ready,
    output logic [AWIDTH-1:0]  addr_b0,
    output logic               ce_b0,
    output logic               we_b0,
    output logic [DWIDTH-1:0]  d_b0,
    output logic [AWIDTH-1:0]  addr_b1,
    output logic               ce_b1,
    output logic               we_b1,
    output logic [DWIDTH-1:0]  d_b1,
    output logic [AWIDTH-1:0]  addr_b2,
    output logic               ce_b2,
    output logic               we_b2,
    output logic [DWIDTH-1:0]  d_b2
);

    state_t             state_q, state_d;
    logic [CNT_BIT-1:0] num_q,   num_d;
    logic [AWIDTH-1:0]  addr_q,  addr_d;
    logic               done_q,  done_d;

    logic [CNT_BIT-1:0] num_clamp;
    logic               beat;
    logic               last_beat;
    logic [2:0]         wr_en;

    assign beat      = s_valid & s_ready;
    assign last_beat = beat && (CNT_BIT'(addr_q) == (num_q - CNT_BIT'(1)));

    // Clamping at latch time bounds the address counter to MEM_SIZE-1.
    always_comb begin
        num_clamp = i_num_cnt;
        if (i_num_cnt > CNT_BIT'(MEM_SIZE))
            num_clamp = CNT_BIT'(MEM_SIZE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        addr_d  = addr_q;
        done_d  = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    num_d   = num_clamp;
                    addr_d  = '0;
                    state_d = (num_clamp == '0) ? ST_DONE : ST_LOAD_B0;
                end
            end
            ST_LOAD_B0, ST_LOAD_B1, ST_LOAD_B2: begin
                if (last_beat) begin
                    addr_d = '0;
                    case (state_q)
                        ST_LOAD_B0: state_d = ST_LOAD_B1;
                        ST_LOAD_B1: state_d = ST_LOAD_B2;
                        default:    state_d = ST_DONE;
                    endcase
                end else if (beat) begin
                    addr_d = addr_q + AWIDTH'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_idle  = (state_q == ST_IDLE);
        o_load  = 1'b0;
        s_ready = 1'b0;
        wr_en   = 3'b000;
        case (state_q)
            ST_LOAD_B0: begin o_load = 1'b1; s_ready = 1'b1; wr_en = {2'b00, s_valid}; end
            ST_LOAD_B1: begin o_load = 1'b1; s_ready = 1'b1; wr_en = {1'b0, s_valid, 1'b0}; end
            ST_LOAD_B2: begin o_load = 1'b1; s_ready = 1'b1; wr_en = {s_valid, 2'b00}; end
            default: ;
        endcase
    end

    assign o_done = done_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DWIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_IDLE && i_run)
            sum_d = '0;
        else if (beat)
            sum_d = sum_q + s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign o_checksum = sum_q;
`endif

    bram_wr_port #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_wr_b0 (
        .clk(clk), .reset_n(reset_n), .i_wr(wr_en[0]), .i_addr(addr_q), .i_data(s_data),
        .o_addr(addr_b0), .o_ce(ce_b0), .o_we(we_b0), .o_d(d_b0)
    );

    bram_wr_port #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_wr_b1 (
        .clk(clk), .reset_n(reset_n), .i_wr(wr_en[1]), .i_addr(addr_q), .i_data(s_data),
        .o_addr(addr_b1), .o_ce(ce_b1), .o_we(we_b1), .o_d(d_b1)
    );

    bram_wr_port #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_wr_b2 (
        .clk(clk), .reset_n(reset_n), .i_wr(wr_en[2]), .i_addr(addr_q), .i_data(s_data),
        .o_addr(addr_b2), .o_ce(ce_b2), .o_we(we_b2), .o_d(d_b2)
    );

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: table of load runs plus a mid-load reset sequence.
// Expected bank contents, write targets and o_done timing come from beat-index arithmetic.
// Stream stalls are randomized per run; every wait is bounded by a cycle budget.
module tb_bram_stream_loader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CB = 31;
    localparam int MS = 4096;
    localparam int MAXB = 3 * MS;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_run;
    logic [CB-1:0] i_num_cnt;
    logic          o_idle, o_load, o_done;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic [AW-1:0] addr_b0, addr_b1, addr_b2;
    logic          ce_b0, ce_b1, ce_b2, we_b0, we_b1, we_b2;
    logic [DW-1:0] d_b0, d_b1, d_b2;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    bram_stream_loader dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_load(o_load), .o_done(o_done),
`ifdef LOADER_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d_b1(d_b1),
        .addr_b2(addr_b2), .ce_b2(ce_b2), .we_b2(we_b2), .d_b2(d_b2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;
        int vmode;
        bit rnd;
        int exp_per_bank;
    } vec_t;

    // Reference state: beat k lands in bank k/n at address k%n.
    logic [DW-1:0] dat [MAXB];
    logic [DW-1:0] mem [3][MS];
    int            mdl_n;
    int            acc_cnt, last_acc_cyc, run_cyc;
    int            done_cnt, done_cyc, ready_cnt, wr_err;
    int            wr_cnt [3];
    int            last_addr [3];
    logic [DW-1:0] chk_at_done;
    bit            exp_wr;
    int            exp_bank;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dat;

    always @(negedge clk) begin : monitor
        logic [2:0] cev, wev, expv;
        logic [AW-1:0] got_a;
        logic [DW-1:0] got_d;
        if (!reset_n) begin
            exp_wr = 1'b0;
        end else begin
            cev = {ce_b2, ce_b1, ce_b0};
            wev = {we_b2, we_b1, we_b0};
            if (ce_b0 && we_b0) mem[0][addr_b0] = d_b0;
            if (ce_b1 && we_b1) mem[1][addr_b1] = d_b1;
            if (ce_b2 && we_b2) mem[2][addr_b2] = d_b2;
            if (exp_wr) begin
                expv  = 3'b001 << exp_bank;
                got_a = (exp_bank == 0) ? addr_b0 : (exp_bank == 1) ? addr_b1 : addr_b2;
                got_d = (exp_bank == 0) ? d_b0 : (exp_bank == 1) ? d_b1 : d_b2;
                if (cev != expv || wev != expv || got_a != exp_addr || got_d != exp_dat)
                    wr_err++;
                wr_cnt[exp_bank]++;
                last_addr[exp_bank] = int'(got_a);
            end else if (cev != 3'b000 || wev != 3'b000) begin
                wr_err++;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef LOADER_CHECKSUM_EN
                chk_at_done = o_checksum;
`endif
            end
            if (s_ready) ready_cnt++;
            exp_wr = 1'b0;
            if (s_valid && s_ready) begin
                if (mdl_n == 0 || acc_cnt >= 3 * mdl_n) begin
                    wr_err++;
                end else begin
                    exp_wr   = 1'b1;
                    exp_bank = acc_cnt / mdl_n;
                    exp_addr = AW'(acc_cnt % mdl_n);
                    exp_dat  = s_data;
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic start_model(input int n, input bit rnd);
        for (int k = 0; k < MAXB; k++) dat[k] = rnd ? DW'($urandom) : DW'(k + 1);
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < MS; a++) mem[b][a] = 32'hA5A5_5A5A;
            wr_cnt[b]    = 0;
            last_addr[b] = -1;
        end
        mdl_n = n; acc_cnt = 0; done_cnt = 0; ready_cnt = 0; wr_err = 0;
        last_acc_cyc = 0; done_cyc = 0; chk_at_done = '0;
    endtask

    task automatic launch(input int cnt);
        @(posedge clk); #1;
        i_num_cnt = CB'(cnt);
        i_run     = 1'b1;
        run_cyc   = cyc;
        @(posedge clk); #1;
        i_run = 1'b0;
    endtask

    task automatic do_run(input vec_t v, input string tag);
        int total, guard, phase, errs, exp_done;
        logic [DW-1:0] sum;
        total = 3 * v.exp_per_bank;
        start_model(v.exp_per_bank, v.rnd);
        launch(v.cnt);
        guard = 0; phase = 0;
        while (acc_cnt < total && guard < 40000) begin
            case (v.vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (phase % 2 == 0);
                default: s_valid = ($urandom_range(0, 3) != 0);
            endcase
            // Stray run requests mid-load must be ignored.
            if (v.vmode == 2) begin
                i_run     = ($urandom_range(0, 7) == 0);
                i_num_cnt = CB'(2);
            end
            s_data = dat[acc_cnt];
            phase++; guard++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        i_run   = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        exp_done = (total == 0) ? run_cyc + 2 : last_acc_cyc + 2;
        chk($sformatf("%s.beats", tag), acc_cnt, total);
        for (int b = 0; b < 3; b++)
            chk($sformatf("%s.writes_b%0d", tag, b), wr_cnt[b], v.exp_per_bank);
        chk($sformatf("%s.write_pulses", tag), wr_err, 0);
        chk($sformatf("%s.done_count", tag), done_cnt, 1);
        chk($sformatf("%s.done_cycle", tag), done_cyc, exp_done);
        errs = 0;
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < v.exp_per_bank; a++)
                if (mem[b][a] != dat[b * v.exp_per_bank + a]) errs++;
        chk($sformatf("%s.contents", tag), errs, 0);
        if (v.exp_per_bank == 0)
            chk($sformatf("%s.ready_cycles", tag), ready_cnt, 0);
        else
            for (int b = 0; b < 3; b++)
                chk($sformatf("%s.last_addr_b%0d", tag, b), last_addr[b], v.exp_per_bank - 1);
        chk($sformatf("%s.idle_after", tag), longint'(o_idle), 1);
`ifdef LOADER_CHECKSUM_EN
        sum = '0;
        for (int k = 0; k < total; k++) sum = sum + dat[k];
        chk($sformatf("%s.checksum", tag), longint'(chk_at_done), longint'(sum));
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s.idle", tag), longint'(o_idle), 1);
        chk($sformatf("%s.load_ready_done", tag), longint'({o_load, s_ready, o_done}), 0);
        chk($sformatf("%s.ce_we", tag), longint'({ce_b2, ce_b1, ce_b0, we_b2, we_b1, we_b0}), 0);
        chk($sformatf("%s.addr", tag), longint'({addr_b2, addr_b1, addr_b0}), 0);
        chk($sformatf("%s.data_or", tag), longint'(d_b0 | d_b1 | d_b2), 0);
    endtask

    vec_t tbl [7];

    initial begin
        int guard;
        tbl[0] = '{cnt: 4,    vmode: 0, rnd: 1'b0, exp_per_bank: 4};
        tbl[1] = '{cnt: 4,    vmode: 1, rnd: 1'b0, exp_per_bank: 4};
        tbl[2] = '{cnt: 0,    vmode: 0, rnd: 1'b0, exp_per_bank: 0};
        tbl[3] = '{cnt: 5000, vmode: 0, rnd: 1'b1, exp_per_bank: 4096};
        tbl[4] = '{cnt: 3,    vmode: 2, rnd: 1'b1, exp_per_bank: 3};
        tbl[5] = '{cnt: 1,    vmode: 2, rnd: 1'b1, exp_per_bank: 1};
        tbl[6] = '{cnt: 7,    vmode: 2, rnd: 1'b1, exp_per_bank: 7};

        reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0; s_valid = 1'b0; s_data = '0;
        mdl_n = 0; exp_wr = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 7; i++) do_run(tbl[i], $sformatf("run%0d_n%0d", i, tbl[i].cnt));

        // Reset asserted in bank 1 with the counter at 2.
        start_model(4, 1'b0);
        launch(4);
        guard = 0;
        while (acc_cnt < 6 && guard < 100) begin
            s_valid = 1'b1;
            s_data  = dat[acc_cnt];
            guard++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst.pre_b0", wr_cnt[0], 4);
        chk("midrst.pre_b1", wr_cnt[1], 2);
        chk("midrst.pre_load", longint'(o_load), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst.now");
        s_valid = 1'b1; i_run = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst.held");
        @(posedge clk); #1;
        s_valid = 1'b0; i_run = 1'b0;
        reset_n = 1'b1;
        do_run('{cnt: 4, vmode: 0, rnd: 1'b1, exp_per_bank: 4}, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
